// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - operation request / completion interface of the execute stage
interface alu_exec_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [AW-1:0]     in_rd;
  logic [AW-1:0]     in_rs1;
  logic [AW-1:0]     in_rs2;
  logic              in_imm_en;
  logic [DATA_W-1:0] in_imm;
  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [5:0]        out_flags;
  logic              out_illegal;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    input  in_ready, out_valid, out_result, out_flags, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    output in_ready, out_valid, out_result, out_flags, out_illegal
  );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute-stage controller wrapping a combinational ALU
// Four-state sequencer: IDLE accept, READ operands, EXEC sample ALU, WB write back.
module alu_exec_stage #(
  parameter  int REG_COUNT = 8,
  parameter  int DATA_W    = 16,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  alu_exec_if.slave         bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_f,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [5:0]        alu_status,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [5:0]        flags_q;
  logic [5:0]        st_q;
  logic [4:0]        op_q;
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     rs1_q;
  logic [AW-1:0]     rs2_q;
  logic              imm_en_q;
  logic [DATA_W-1:0] imm_q;
  logic              op_ok;

  function automatic logic op_legal(input logic [4:0] f);
    return f inside {5'd1, 5'd3, [5'd4:5'd11], [5'd16:5'd23]};
  endfunction

  assign op_ok    = op_legal(op_q);
  assign dbg_data = regs[dbg_addr];

  // out_result doubles as the captured result register; alu_a/alu_b double as the operand latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      flags_q         <= '0;
      st_q            <= '0;
      op_q            <= '0;
      rd_q            <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      imm_en_q        <= 1'b0;
      imm_q           <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_f           <= '0;
      alu_cin         <= 1'b0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.out_illegal <= 1'b0;
      bus.out_result  <= '0;
      bus.out_flags   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.out_valid   <= 1'b0;
          bus.out_illegal <= 1'b0;
          if (bus.in_valid) begin
            op_q         <= bus.in_op;
            rd_q         <= bus.in_rd;
            rs1_q        <= bus.in_rs1;
            rs2_q        <= bus.in_rs2;
            imm_en_q     <= bus.in_imm_en;
            imm_q        <= bus.in_imm;
            bus.in_ready <= 1'b0;
            state        <= READ;
          end
        end
        READ: begin
          alu_a   <= regs[rs1_q];
          alu_b   <= imm_en_q ? imm_q : regs[rs2_q];
          alu_f   <= op_q;
          alu_cin <= flags_q[5];
          state   <= EXEC;
        end
        EXEC: begin
          st_q            <= alu_status;
          bus.out_result  <= alu_result;
          bus.out_flags   <= op_ok ? alu_status : flags_q;
          bus.out_illegal <= ~op_ok;
          bus.out_valid   <= 1'b1;
          state           <= WB;
        end
        WB: begin
          if (!bus.out_illegal) begin
            regs[rd_q] <= bus.out_result;
            flags_q    <= st_q;
          end
          bus.out_valid   <= 1'b0;
          bus.out_illegal <= 1'b0;
          bus.in_ready    <= 1'b1;
          state           <= IDLE;
        end
        default: begin
          bus.in_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage with a behavioural ALU
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_a, alu_b, alu_result, dbg_data;
  logic [4:0]  alu_f;
  logic        alu_cin;
  logic [5:0]  alu_status;
  logic [2:0]  dbg_addr = '0;

  alu_exec_if #(.DATA_W(16), .AW(3)) bus ();

  alu_exec_stage #(.REG_COUNT(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_status(alu_status),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Environment ALU: returns {C,Z,N,O,P,AC,result}
  function automatic logic [21:0] ref_alu(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] w;
    logic [15:0] r;
    logic c, o, ac;
    c = 1'b0; o = 1'b0; ac = 1'b0; w = '0;
    case (f)
      5'd1:  begin w = {1'b0, a} + 17'd1; r = w[15:0]; c = w[16]; o = ~a[15] & r[15]; end
      5'd3:  begin w = {1'b0, a} - 17'd1; r = w[15:0]; c = w[16]; o = a[15] & ~r[15]; end
      5'd4, 5'd5: begin
        w = {1'b0, a} + {1'b0, b} + ((f == 5'd5) ? {16'd0, cin} : 17'd0);
        r = w[15:0]; c = w[16]; o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      5'd6, 5'd7: begin
        w = {1'b0, a} - {1'b0, b} - ((f == 5'd7) ? {16'd0, cin} : 17'd0);
        r = w[15:0]; c = w[16]; o = (a[15] != b[15]) && (r[15] != a[15]);
        ac = a[3:0] < b[3:0];
      end
      5'd8:  r = a & b;
      5'd9:  r = a | b;
      5'd10: r = a ^ b;
      5'd11: r = ~a;
      5'd16: begin r = {a[14:0], 1'b0}; c = a[15]; end
      5'd17: begin r = {1'b0, a[15:1]}; c = a[0]; end
      5'd18: begin r = {a[15], a[15:1]}; c = a[0]; end
      5'd19: begin r = {a[14:0], a[15]}; c = a[15]; end
      5'd20: begin r = {a[0], a[15:1]}; c = a[0]; end
      5'd21: r = b;
      5'd22: begin r = {a[14:0], cin}; c = a[15]; end
      5'd23: begin r = {cin, a[15:1]}; c = a[0]; end
      default: begin r = a ^ b ^ 16'hA5A5; c = 1'b1; o = 1'b1; ac = 1'b1; end
    endcase
    return {c, (r == 16'd0), r[15], o, ~^r, ac, r};
  endfunction

  always_comb {alu_status, alu_result} = ref_alu(alu_f, alu_a, alu_b, alu_cin);

  typedef struct {
    logic [15:0] res;
    logic [5:0]  fl;
    logic        ill;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mregs [8];
  logic [5:0]  mflags;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulse_cyc[$];
  int          acc_cyc[$];
  logic [15:0] last_res;
  logic [5:0]  last_fl;
  logic        last_ill;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mflags = '0;
    sbq.delete();
  endtask

  // Architectural effect of one op, in issue order
  task automatic model_push(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm);
    logic [21:0] o;
    logic legal;
    exp_t e;
    o = ref_alu(op, mregs[rs1], imm_en ? imm : mregs[rs2], mflags[5]);
    legal = (op == 5'd1) || (op == 5'd3) || (op >= 5'd4 && op <= 5'd11) || (op >= 5'd16 && op <= 5'd23);
    e.res = o[15:0];
    e.ill = ~legal;
    if (legal) begin
      mregs[rd] = o[15:0];
      mflags    = o[21:16];
    end
    e.fl = mflags;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && bus.out_valid) begin
      pulse_cyc.push_back(cyc);
      last_res = bus.out_result;
      last_fl  = bus.out_flags;
      last_ill = bus.out_illegal;
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_result", {16'd0, bus.out_result}, {16'd0, e.res});
        chk("out_flags", {26'd0, bus.out_flags}, {26'd0, e.fl});
        chk("out_illegal", {31'd0, bus.out_illegal}, {31'd0, e.ill});
      end
    end
  end

  task automatic set_fields(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm);
    bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1;
    bus.in_rs2 = rs2; bus.in_imm_en = imm_en; bus.in_imm = imm;
  endtask

  // Called at a falling edge; returns at the falling edge of the READ cycle
  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm);
    int n;
    n = 0;
    set_fields(op, rd, rs1, rs2, imm_en, imm);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      model_push(op, rd, rs1, rs2, imm_en, imm);
      acc_cyc.push_back(cyc);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Returns at the falling edge of the cycle after WB
  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm);
    issue(op, rd, rs1, rs2, imm_en, imm);
    wait_done();
  endtask

  initial begin
    int acc;
    bus.in_valid = 1'b0;
    set_fields('0, '0, '0, '0, 1'b0, '0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
    chk("rst_alu_abfc", {alu_a, alu_b} | {26'd0, alu_f, alu_cin}, 32'd0);
    chk("rst_dbg", {16'd0, dbg_data}, 32'd0);

    run_op(5'd4, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF);
    chk("t1_res0", {16'd0, last_res}, 32'h7FFF);
    chk("t1_fl0", {26'd0, last_fl}, 32'h00);
    run_op(5'd4, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001);
    chk("t1_res1", {16'd0, last_res}, 32'h8000);
    chk("t1_fl1", {26'd0, last_fl}, 32'b001100);
    dbg_addr = 3'd2; #1;
    chk("t1_dbg_r2", {16'd0, dbg_data}, 32'h8000);

    run_op(5'd4, 3'd3, 3'd0, 3'd0, 1'b1, 16'hFFFF);
    run_op(5'd4, 3'd4, 3'd3, 3'd0, 1'b1, 16'h0001);
    chk("t2_res_wrap", {16'd0, last_res}, 32'h0000);
    chk("t2_fl_czp", {26'd0, last_fl}, 32'b110010);
    issue(5'd5, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0000);
    @(negedge clk);
    chk("t2_adc_cin", {31'd0, alu_cin}, 32'd1);
    wait_done();
    chk("t2_adc_res", {16'd0, last_res}, 32'h0001);
    run_op(5'd4, 3'd4, 3'd3, 3'd0, 1'b1, 16'h0001);
    run_op(5'd22, 3'd6, 3'd0, 3'd0, 1'b0, 16'h0000);
    chk("t2_rcl_res", {16'd0, last_res}, 32'h0001);

    run_op(5'd0, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000);
    chk("t3_illegal", {31'd0, last_ill}, 32'd1);
    chk("t3_flags_kept", {26'd0, last_fl}, 32'h00);
    dbg_addr = 3'd1; #1;
    chk("t3_r1_kept", {16'd0, dbg_data}, 32'h7FFF);

    for (int k = 0; k < 3; k++) begin
      run_op(5'd1, 3'd1, 3'd1, 3'd0, 1'b0, 16'h0000);
      chk("t6_inc_dbg", {16'd0, dbg_data}, 32'h8000 + k);
    end

    pulse_cyc.delete();
    acc_cyc.delete();
    acc = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (acc < 3) set_fields(5'd6 + 5'(acc), 3'(acc + 3), 3'(acc + 1), 3'd2, acc[0], 16'h0101 * 16'(acc + 1));
      chk("t4_ready_pattern", {31'd0, bus.in_ready}, {31'd0, (i % 4) == 0});
      if (bus.in_ready && acc < 3) begin
        model_push(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm_en, bus.in_imm);
        acc_cyc.push_back(cyc);
        acc++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_pulse_count", pulse_cyc.size(), 32'd3);
    for (int j = 0; j < 3; j++) begin
      if (j < pulse_cyc.size() && j < acc_cyc.size())
        chk("t4_latency", pulse_cyc[j] - acc_cyc[j], 32'd3);
    end

    dbg_addr = 3'd7;
    issue(5'd4, 3'd7, 3'd0, 3'd0, 1'b1, 16'h1234);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    pulse_cyc.delete();
    @(negedge clk);
    chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t5_r7_zero", {16'd0, dbg_data}, 32'd0);
    repeat (4) @(negedge clk);
    chk("t5_no_pulse", pulse_cyc.size(), 32'd0);
    run_op(5'd31, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0000);
    chk("t5_flags_zero", {26'd0, last_fl}, 32'd0);

    repeat (150) begin
      run_op(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom));
      dbg_addr = 3'($urandom_range(0, 7)); #1;
      chk("rand_dbg", {16'd0, dbg_data}, {16'd0, mregs[dbg_addr]});
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
